// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a shared multi-digit 7-segment display.
// Host writes land in a shadow image that is copied to the displayed image only at a frame boundary.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_idx,
  input  logic [3:0]            wr_data,
  input  logic                  wr_blank,
  input  logic                  wr_last,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [4:0]       ENTRY_DARK = 5'h10;
  localparam logic [6:0]       SEG_OFF    = 7'h7F;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             pending;
  logic [4:0]       shadow [NUM_DIGITS];
  logic [4:0]       active [NUM_DIGITS];

  logic   slot_end;
  logic   wrap;
  logic   wr_xfer;
  logic   wr_hit;
  phase_t phase;

  function automatic logic [6:0] seg_decode(input logic [4:0] entry);
    logic [6:0] pat;
    if (entry[4]) begin
      pat = SEG_OFF;
    end else begin
      case (entry[3:0])
        4'h0: pat = 7'h40;
        4'h1: pat = 7'h79;
        4'h2: pat = 7'h24;
        4'h3: pat = 7'h30;
        4'h4: pat = 7'h19;
        4'h5: pat = 7'h12;
        4'h6: pat = 7'h02;
        4'h7: pat = 7'h78;
        4'h8: pat = 7'h00;
        4'h9: pat = 7'h10;
        4'hA: pat = 7'h08;
        4'hB: pat = 7'h03;
        4'hC: pat = 7'h46;
        4'hD: pat = 7'h21;
        4'hE: pat = 7'h06;
        default: pat = 7'h0E;
      endcase
    end
    return pat;
  endfunction

  assign slot_end   = (cnt == CNT_LAST);
  assign wrap       = slot_end && (idx == IDX_LAST);
  assign frame_done = wrap;
  assign wr_ready   = ~pending;
  assign wr_xfer    = wr_valid && wr_ready;
  assign wr_hit     = ({1'b0, wr_idx} < 4'(NUM_DIGITS));
  assign phase      = (cnt < CNT_BLANK) ? PH_BLANK : PH_SHOW;

  // Slot timing: cnt walks through one digit slot, idx selects the digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // While pending, wr_ready is low, so a commit and a shadow write never
  // coincide; a wr_last accepted on the wrap itself waits for the next wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= ENTRY_DARK;
        active[i] <= ENTRY_DARK;
      end
    end else begin
      if (wrap && pending) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active[i] <= shadow[i];
        end
        pending <= 1'b0;
      end
      if (wr_xfer) begin
        if (wr_hit) begin
          shadow[wr_idx[IDX_W-1:0]] <= {wr_blank, wr_data};
        end
        if (wr_last) begin
          pending <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else if (phase == PH_BLANK) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else begin
      seg <= seg_decode(active[idx]);
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a time-based reference model predicts outputs per cycle,
// predictions are queued at drive time and compared after the edge, plus directed spot checks.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 10;
  localparam int BC = 2;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [2:0]    wr_idx;
  logic [3:0]    wr_data;
  logic          wr_blank;
  logic          wr_last;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          frame_done;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_blank(wr_blank), .wr_last(wr_last),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  string cur_tag = "reset";

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state: cycles since reset, shadow/active images, pending flag
  int         mt = 0;
  logic [4:0] m_sh  [ND];
  logic [4:0] m_act [ND];
  logic       m_pend = 1'b0;

  task automatic step();
    exp_t e;
    exp_t obs;
    int c, d;
    logic wrap, xfer;
    c = mt % SD;
    d = (mt / SD) % ND;
    if (c < BC) begin
      e.seg = 7'h7F;
      e.an  = 4'hF;
    end else begin
      e.an  = 4'hF & ~(4'b0001 << d);
      e.seg = m_act[d][4] ? 7'h7F : dec_tab[m_act[d][3:0]];
    end
    if (rst) begin
      e.seg = 7'h7F;
      e.an  = 4'hF;
      mt = 0;
      m_pend = 1'b0;
      for (int i = 0; i < ND; i++) begin
        m_sh[i] = 5'h10;
        m_act[i] = 5'h10;
      end
    end else begin
      wrap = (c == SD - 1) && (d == ND - 1);
      xfer = wr_valid && !m_pend;
      if (wrap && m_pend) begin
        for (int i = 0; i < ND; i++) m_act[i] = m_sh[i];
        m_pend = 1'b0;
      end
      if (xfer) begin
        if (wr_idx < 3'(ND)) m_sh[wr_idx] = {wr_blank, wr_data};
        if (wr_last) m_pend = 1'b1;
      end
      mt++;
    end
    e.fd  = (mt % SD == SD - 1) && ((mt / SD) % ND == ND - 1);
    e.rdy = !m_pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    obs = '{seg: seg, an: an, fd: frame_done, rdy: wr_ready};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s t=%0d: got seg=%h an=%h fd=%b rdy=%b want seg=%h an=%h fd=%b rdy=%b",
             cur_tag, mt, obs.seg, obs.an, obs.fd, obs.rdy, e.seg, e.an, e.fd, e.rdy);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_write(input logic [2:0] i, input logic [3:0] d, input logic b, input logic l);
    wr_valid = 1'b1;
    wr_idx   = i;
    wr_data  = d;
    wr_blank = b;
    wr_last  = l;
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_blank = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (an !== target && n < 60) begin
      step();
      n++;
    end
    if (an !== target) begin
      checks++;
      errors++;
      $error("FAIL %s timeout: an=%h want %h", tag, an, target);
    end
  endtask

  // wait for the next fresh SHOW slot of digit d, then check its pattern
  task automatic check_digit(input int d, input logic [6:0] want, input string tag);
    logic [3:0] t;
    int n;
    t = 4'hF & ~(4'b0001 << d);
    n = 0;
    while (an === t && n < 60) begin
      step();
      n++;
    end
    wait_an(t, tag);
    checks++;
    assert (seg === want) else begin
      errors++;
      $error("FAIL %s: digit%0d seg=%h want %h", tag, d, seg, want);
    end
  endtask

  initial begin
    int fd_cnt;
    int dark_bad;
    for (int i = 0; i < ND; i++) begin
      m_sh[i] = 5'h10;
      m_act[i] = 5'h10;
    end
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_idx = '0;
    wr_data = '0;
    wr_blank = 1'b0;
    wr_last = 1'b0;
    @(negedge clk);

    cur_tag = "reset";
    idle(3);
    rst = 1'b0;

    cur_tag = "scan";
    fd_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (frame_done === 1'b1) fd_cnt++;
    end
    checks++;
    assert (fd_cnt == 2) else begin
      errors++;
      $error("FAIL frame_done_count: got %0d want 2", fd_cnt);
    end

    cur_tag = "image_load";
    do_write(3'd0, 4'h1, 1'b0, 1'b0);
    do_write(3'd1, 4'h2, 1'b0, 1'b0);
    do_write(3'd2, 4'h3, 1'b0, 1'b0);
    do_write(3'd3, 4'h4, 1'b0, 1'b1);
    checks++;
    assert (wr_ready === 1'b0) else begin
      errors++;
      $error("FAIL ready_after_last: got %b want 0", wr_ready);
    end
    check_digit(0, 7'h79, "load_d0");
    check_digit(1, 7'h24, "load_d1");
    check_digit(2, 7'h30, "load_d2");
    check_digit(3, 7'h19, "load_d3");

    cur_tag = "tear_free";
    wait_an(4'hB, "tear_wait");
    do_write(3'd2, 4'h8, 1'b0, 1'b0);
    idle(80);
    check_digit(2, 7'h30, "tear_d2");

    cur_tag = "edge";
    do_write(3'd1, 4'h9, 1'b1, 1'b0);
    do_write(3'd5, 4'h7, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < 50) begin
        step();
        n++;
      end
      if (frame_done !== 1'b1) begin
        checks++;
        errors++;
        $error("FAIL wrap_wait timeout: frame_done=%b want 1", frame_done);
      end
    end
    do_write(3'd3, 4'h4, 1'b0, 1'b1);
    checks++;
    assert (wr_ready === 1'b0) else begin
      errors++;
      $error("FAIL ready_wrap_last: got %b want 0", wr_ready);
    end
    check_digit(1, 7'h24, "edge_d1_old");
    check_digit(1, 7'h7F, "edge_d1_dark");
    check_digit(2, 7'h00, "edge_d2");
    check_digit(3, 7'h19, "edge_d3");
    check_digit(0, 7'h79, "edge_d0");

    cur_tag = "mid_reset";
    do_write(3'd0, 4'h0, 1'b0, 1'b1);
    wait_an(4'hB, "mid_wait");
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    assert ({seg, an, wr_ready} === {7'h7F, 4'hF, 1'b1}) else begin
      errors++;
      $error("FAIL mid_reset: got seg=%h an=%h rdy=%b want seg=7f an=f rdy=1", seg, an, wr_ready);
    end
    dark_bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (seg !== 7'h7F) dark_bad++;
    end
    checks++;
    assert (dark_bad == 0) else begin
      errors++;
      $error("FAIL dark_after_reset: got %0d lit cycles want 0", dark_bad);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
